venc1_crc_attach: RTL and testbench
===================================

VENC1_CRC_ATTACH -- requirements
Module: venc1_crc_attach

Interface
- REQ-001 No parameters; all widths are fixed constants from the shared package.
- REQ-002 clk  input  1  single clock; all logic on its rising edge.
- REQ-003 rst  input  1  reset, synchronous, active-low.
- REQ-004 start  input  1  one-cycle pulse; loads a new frame; honoured only when busy=0.
- REQ-005 info_bits  input  21  info payload; bit 0 is transmitted first.
- REQ-006 info_len  input  5  number of info bits to send; sampled with start.
- REQ-007 busy  output  1  high from the cycle after an accepted start until done.
- REQ-008 bit_out  output  1  serial output bit.
- REQ-009 bit_valid  output  1  bit_out holds a valid bit.
- REQ-010 bit_ready  input  1  downstream accepts; a bit transfers when bit_valid=1 and bit_ready=1.
- REQ-011 crc_out  output  16  final CRC value, valid from done until the next accepted start.
- REQ-012 done  output  1  one-cycle pulse after the last CRC bit transfers.

Function
- REQ-013 The CRC shall be serial CRC-16, polynomial 0x1021, init 0x0000; per info bit: fb = bit ^ crc[15]; crc = {crc[14:0],0} ^ (fb ? 0x1021 : 0).
- REQ-014 The FSM shall have states IDLE, INFO, CRC and FIN.
- REQ-015 IDLE: on start, latch info_bits, load bit count = min(info_len,21), clear crc; go to INFO, or to CRC if the count is 0.
- REQ-016 INFO: bit_valid=1 and bit_out = info_cache[0]; on each transfer, shift the cache right, update crc, and decrement the count; after the last info transfer go to CRC.
- REQ-017 CRC: bit_valid=1; emit 16 CRC bits MSB first (crc[15] first) by shifting a 16-bit register left on each transfer; after the 16th transfer go to FIN.
- REQ-018 FIN: done=1 for one cycle, crc_out holds the final CRC, busy drops; return to IDLE.
- REQ-019 Latency: start in cycle N puts the first bit valid in cycle N+1; a frame is info_len+16 transfers long.
- REQ-020 bit_out, and the CRC and count state, shall stay unchanged while bit_valid=1 and bit_ready=0.
- REQ-021 start while busy=1 (including the FIN cycle) shall be ignored with no effect.
- REQ-022 info_len values 22..31 shall be clamped to 21.
- REQ-023 bit_valid shall be 0 in IDLE and FIN.

Reset
- REQ-024 With rst=0 at a clock edge: state=IDLE; busy=0, bit_valid=0, bit_out=0, done=0, crc_out=0x0000; internal cache, count and crc cleared.
- REQ-025 Reset mid-frame shall abort the frame with no done pulse; the block accepts a new start in the first cycle after rst returns high.

Configuration
- REQ-026 Macro VENC1_CRC_INV_EN defined: the CRC is bitwise inverted (xor 0xFFFF) both on the serial bits emitted and on crc_out.
- REQ-027 Macro VENC1_CRC_INV_EN undefined: the CRC is emitted and reported uninverted.

Structure
- REQ-028 Package venc1_crc_pkg shall hold INFO_W=21, LEN_W=5, CRC_W=16, CRC_POLY=16'h1021, CRC_INIT=16'h0000 and the FSM state enum.
- REQ-029 A combinational sub-module venc1_crc16_step (1-bit input, 16-bit current crc, 16-bit next crc) shall implement REQ-013.

Verification
- REQ-030 info_len=1, info_bits=1, bit_ready=1 -> bits: 1, then 0001000000100001; crc_out=0x1021; done pulses 18 cycles after start.
- REQ-031 info_len=0 -> 16 zero bits; crc_out=0x0000. With VENC1_CRC_INV_EN -> 16 one bits; crc_out=0xFFFF.
- REQ-032 info_len=21, random info_bits, bit_ready low for 5 cycles after bit 7 -> bit_out stable during the stall; 37 transfers total; crc_out matches the reference model.
- REQ-033 start re-pulsed during the CRC phase with different info_bits -> the frame completes unchanged; the new start is ignored.
- REQ-034 rst low for 1 cycle during INFO -> all outputs at reset values, no done; a new start 1 cycle after reset produces a correct frame.
- REQ-035 info_len=31, info_bits=21'h1FFFFF -> exactly 21 info bits, then 16 CRC bits.

Source files
------------

// File: rtl/venc1_crc_pkg.sv
// Shared widths, CRC constants and FSM state encoding for the venc1 CRC attach block.
package venc1_crc_pkg;

  localparam int unsigned INFO_W    = 21;
  localparam int unsigned LEN_W     = 5;
  localparam int unsigned CRC_W     = 16;
  localparam int unsigned CRC_CNT_W = 4;

  localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
  localparam logic [CRC_W-1:0] CRC_INIT = 16'h0000;

  typedef enum logic [1:0] {
    StIdle,
    StInfo,
    StCrc,
    StFin
  } state_e;

endpackage

// File: rtl/venc1_crc16_step.sv
// One serial step of CRC-16 (poly 0x1021): feeds one message bit into the current remainder.
module venc1_crc16_step
  import venc1_crc_pkg::*;
(
  input  logic             bit_in,
  input  logic [CRC_W-1:0] crc_cur,
  output logic [CRC_W-1:0] crc_next
);

  logic fb;

  always_comb begin
    fb       = bit_in ^ crc_cur[CRC_W-1];
    crc_next = {crc_cur[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  end

endmodule

// File: rtl/venc1_crc_attach.sv
// Serialises an info payload LSB first and appends its CRC-16 MSB first, with valid/ready flow.
// Optional macro VENC1_CRC_INV_EN inverts the emitted and reported CRC.
module venc1_crc_attach
  import venc1_crc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [INFO_W-1:0] info_bits,
  input  logic [LEN_W-1:0]  info_len,
  output logic              busy,
  output logic              bit_out,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic [CRC_W-1:0]  crc_out,
  output logic              done
);

`ifdef VENC1_CRC_INV_EN
  localparam logic [CRC_W-1:0] CrcXor = 16'hFFFF;
`else
  localparam logic [CRC_W-1:0] CrcXor = 16'h0000;
`endif

  state_e                 state_q, state_d;
  logic [INFO_W-1:0]      cache_q, cache_d;
  logic [LEN_W-1:0]       count_q, count_d;
  logic [CRC_W-1:0]       crc_q, crc_d;
  logic [CRC_W-1:0]       shift_q, shift_d;
  logic [CRC_CNT_W-1:0]   crc_cnt_q, crc_cnt_d;
  logic [CRC_W-1:0]       crc_out_q, crc_out_d;
  logic [CRC_W-1:0]       crc_step;
  logic [LEN_W-1:0]       len_clamped;

  assign len_clamped = (info_len > LEN_W'(INFO_W)) ? LEN_W'(INFO_W) : info_len;
  assign crc_out     = crc_out_q;

  venc1_crc16_step u_step (
    .bit_in   (cache_q[0]),
    .crc_cur  (crc_q),
    .crc_next (crc_step)
  );

  always_comb begin
    state_d   = state_q;
    cache_d   = cache_q;
    count_d   = count_q;
    crc_d     = crc_q;
    shift_d   = shift_q;
    crc_cnt_d = crc_cnt_q;
    crc_out_d = crc_out_q;
    busy      = 1'b0;
    bit_valid = 1'b0;
    bit_out   = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          cache_d   = info_bits;
          count_d   = len_clamped;
          crc_d     = CRC_INIT;
          crc_cnt_d = '0;
          if (len_clamped == '0) begin
            shift_d = CRC_INIT ^ CrcXor;
            state_d = StCrc;
          end else begin
            state_d = StInfo;
          end
        end
      end
      StInfo: begin
        busy      = 1'b1;
        bit_valid = 1'b1;
        bit_out   = cache_q[0];
        if (bit_ready) begin
          cache_d = cache_q >> 1;
          crc_d   = crc_step;
          count_d = count_q - 1'b1;
          // Load the emit register straight from the final step so no bubble precedes CRC bits.
          if (count_q == LEN_W'(1)) begin
            shift_d = crc_step ^ CrcXor;
            state_d = StCrc;
          end
        end
      end
      StCrc: begin
        busy      = 1'b1;
        bit_valid = 1'b1;
        bit_out   = shift_q[CRC_W-1];
        if (bit_ready) begin
          shift_d   = {shift_q[CRC_W-2:0], 1'b0};
          crc_cnt_d = crc_cnt_q + 1'b1;
          if (crc_cnt_q == CRC_CNT_W'(CRC_W - 1)) begin
            crc_out_d = crc_q ^ CrcXor;
            state_d   = StFin;
          end
        end
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      cache_q   <= '0;
      count_q   <= '0;
      crc_q     <= CRC_INIT;
      shift_q   <= '0;
      crc_cnt_q <= '0;
      crc_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cache_q   <= cache_d;
      count_q   <= count_d;
      crc_q     <= crc_d;
      shift_q   <= shift_d;
      crc_cnt_q <= crc_cnt_d;
      crc_out_q <= crc_out_d;
    end
  end

endmodule

// File: tb/tb_venc1_crc_attach.sv
// Directed bench for venc1_crc_attach: polynomial-division reference model plus per-cycle compare.
module tb_venc1_crc_attach;

`ifdef VENC1_CRC_INV_EN
  localparam logic [15:0] INV = 16'hFFFF;
`else
  localparam logic [15:0] INV = 16'h0000;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [20:0] info_bits;
  logic [4:0]  info_len;
  logic        busy;
  logic        bit_out;
  logic        bit_valid;
  logic        bit_ready;
  logic [15:0] crc_out;
  logic        done;

  venc1_crc_attach dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .info_bits (info_bits),
    .info_len  (info_len),
    .busy      (busy),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .crc_out   (crc_out),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  bit          exp_q[$];
  logic [15:0] exp_crc;
  int          exp_total;
  int          xfers;
  bit          frame_active = 1'b0;
  bit          prev_stall = 1'b0;
  logic        prev_bit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CRC as remainder of M(x)*x^16 mod G(x), first transmitted bit = highest degree.
  function automatic logic [15:0] model_crc(input logic [20:0] bits, input int len);
    logic [16:0] rem;
    int          lc;
    rem = '0;
    lc  = (len > 21) ? 21 : len;
    for (int i = 0; i < lc + 16; i++) begin
      rem = {rem[15:0], (i < lc) ? bits[i] : 1'b0};
      if (rem[16]) rem = rem ^ 17'h11021;
    end
    return rem[15:0];
  endfunction

  task automatic model_load(input logic [20:0] bits, input int len);
    int          lc;
    logic [15:0] c;
    lc = (len > 21) ? 21 : len;
    c  = model_crc(bits, len) ^ INV;
    exp_q.delete();
    for (int i = 0; i < lc; i++) exp_q.push_back(bits[i]);
    for (int i = 15; i >= 0; i--) exp_q.push_back(c[i]);
    exp_crc      = c;
    exp_total    = lc + 16;
    xfers        = 0;
    frame_active = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_bit_valid"}, 32'(bit_valid), 32'd0);
    chk({tag, "_bit_out"}, 32'(bit_out), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_crc_out"}, 32'(crc_out), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (prev_stall) begin
        chk("stall_valid", 32'(bit_valid), 32'd1);
        chk("stall_hold", 32'(bit_out), 32'(prev_bit));
      end
      if (bit_valid && bit_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_bit: got %0d expected no transfer", bit_out);
        end else begin
          chk("bit_out", 32'(bit_out), 32'(exp_q.pop_front()));
        end
        xfers++;
      end
      if (done) begin
        chk("done_expected", 32'(frame_active), 32'd1);
        if (frame_active) begin
          chk("crc_out", 32'(crc_out), 32'(exp_crc));
          chk("transfers", 32'(xfers), 32'(exp_total));
          chk("bits_left", 32'(exp_q.size()), 32'd0);
          frame_active = 1'b0;
        end
      end
      prev_stall = bit_valid && !bit_ready;
      prev_bit   = bit_out;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Entered and left at posedge+1. Optional stall, restart-in-CRC, start-in-FIN and abort.
  task automatic run_frame(input logic [20:0] bits, input logic [4:0] len, input int stall_after,
                           input int restart_at, input bit fin_start, input int abort_at,
                           output int n);
    int          xfer = 0;
    int          stall_left = 0;
    int          total;
    bit          stalled = 1'b0;
    bit          restarted = 1'b0;
    bit          got_done = 1'b0;
    bit          pend_start = 1'b0;
    bit          pend_ready = 1'b1;
    logic [20:0] pend_bits = '0;
    logic [4:0]  pend_len = '0;
    total     = ((int'(len) > 21) ? 21 : int'(len)) + 16;
    start     = 1'b1;
    info_bits = bits;
    info_len  = len;
    bit_ready = 1'b1;
    model_load(bits, int'(len));
    n = 0;
    for (int c = 0; c < 200 && !got_done; c++) begin
      @(posedge clk);
      #1;
      start     = pend_start;
      bit_ready = pend_ready;
      if (pend_start) begin
        info_bits = pend_bits;
        info_len  = pend_len;
      end
      @(negedge clk);
      n++;
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (bit_valid && bit_ready) xfer++;
        pend_start = 1'b0;
        if (stall_after >= 0 && xfer == stall_after && !stalled) begin
          stalled    = 1'b1;
          stall_left = 5;
        end
        pend_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
        if (restart_at >= 0 && xfer == restart_at && !restarted) begin
          restarted  = 1'b1;
          pend_start = 1'b1;
          pend_bits  = ~bits;
          pend_len   = 5'd9;
        end
        if (fin_start && xfer == total) begin
          pend_start = 1'b1;
          pend_bits  = bits ^ 21'h5;
          pend_len   = 5'd3;
        end
        if (abort_at >= 0 && xfer == abort_at) begin
          @(posedge clk);
          #1;
          rst = 1'b0;
          @(posedge clk);
          #1;
          chk_reset_outputs("abort");
          exp_q.delete();
          frame_active = 1'b0;
          rst          = 1'b1;
          return;
        end
      end
    end
    chk("done_seen", 32'(got_done), 32'd1);
    chk("latency", 32'(n), 32'(total + 1 + (stall_after >= 0 ? 5 : 0)));
    @(posedge clk);
    #1;
    start     = 1'b0;
    bit_ready = 1'b1;
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_valid", 32'(bit_valid), 32'd0);
    chk("post_crc_hold", 32'(crc_out), 32'(exp_crc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [20:0] rnd;
    rst       = 1'b0;
    start     = 1'b0;
    info_bits = '0;
    info_len  = '0;
    bit_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    chk("model_len1", 32'(model_crc(21'h1, 1)), 32'h1021);
    chk("model_len0", 32'(model_crc(21'h1, 0)), 32'h0000);
    chk("model_len2", 32'(model_crc(21'h1, 2)), 32'h2042);

    run_frame(21'h000001, 5'd1, -1, -1, 1'b0, -1, n);
    chk("len1_done_cycle", 32'(n), 32'd18);
    chk("len1_crc_literal", 32'(crc_out), 32'(16'h1021 ^ INV));

    run_frame(21'h1ABCDE, 5'd0, -1, -1, 1'b0, -1, n);
    chk("len0_crc_literal", 32'(crc_out), 32'(INV));

    rnd = 21'($urandom);
    run_frame(rnd, 5'd21, 7, -1, 1'b0, -1, n);
    run_frame(21'h00B5A3, 5'd5, -1, 8, 1'b1, -1, n);
    run_frame(21'h012345, 5'd10, -1, -1, 1'b0, 3, n);
    run_frame(21'h00F0F0, 5'd12, -1, -1, 1'b0, -1, n);
    run_frame(21'h1FFFFF, 5'd31, -1, -1, 1'b0, -1, n);
    chk("len31_clamped_cycle", 32'(n), 32'd38);
    run_frame(21'h155555, 5'd21, -1, -1, 1'b0, -1, n);
    run_frame(21'h00FFFF, 5'd16, 3, -1, 1'b0, -1, n);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
